// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS pipeline front end.
//   - opcode constants used by decode/control
//   - default reset PC and the bubble instruction (sll $0,$0,0)
//   - fetch FSM state encoding
//   - opcode_of(): extracts the primary opcode field from an instruction
package mips_pkg;

   localparam logic [5:0] OP_ALU_R = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_BOOT,
      FETCH_ISSUE,
      FETCH_WAIT,
      FETCH_HOLD
   } fetch_state_e;

   function automatic logic [5:0] opcode_of(input logic [31:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register.
//   load_i  : capture {instr_i, pc_plus4_i} and mark valid
//   flush_i : turn the stage into a bubble (valid=0, instr=NOP); wins over load_i
//   neither : hold (this is how a stall keeps IF/ID stable)
// Ports:
//   clk, arst_n            clock, asynchronous active-low reset (resets to a bubble)
//   load_i, flush_i        control
//   instr_i, pc_plus4_i    fetched instruction and its PC+4
//   valid_o, instr_o       IF/ID contents
//   pc_plus4_o, opcode_o   PC+4 of instr_o, instr_o[31:26]
module if_id_pipe_reg
   import mips_pkg::*;
#(
   parameter int unsigned   PC_WIDTH  = 32,
   parameter logic [31:0]   NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                load_i,
   input  logic                flush_i,
   input  logic [31:0]         instr_i,
   input  logic [PC_WIDTH-1:0] pc_plus4_i,
   output logic                valid_o,
   output logic [31:0]         instr_o,
   output logic [PC_WIDTH-1:0] pc_plus4_o,
   output logic [5:0]          opcode_o
);

   logic                valid_d, valid_q;
   logic [31:0]         instr_d, instr_q;
   logic [PC_WIDTH-1:0] pc_plus4_d, pc_plus4_q;

   always_comb begin
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      if (flush_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (load_i) begin
         valid_d    = 1'b1;
         instr_d    = instr_i;
         pc_plus4_d = pc_plus4_i;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_plus4_q <= '0;
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign valid_o    = valid_q;
   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
   assign opcode_o   = opcode_of(instr_q);

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage. Owns the PC, fetches over a req/valid
// handshake (one outstanding request), and fills the IF/ID register.
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   imem_req, imem_addr         one-cycle request strobe and fetch address (= pc)
//   imem_rdata, imem_valid      instruction response
//   stall                       hold PC and IF/ID
//   branch_taken, branch_target redirect (priority over jump)
//   jump, jump_target           redirect
//   if_id_valid, if_id_instr    IF/ID contents (NOP when invalid)
//   if_id_pc_plus4, if_id_opcode
// A response that arrives while stalled is parked in a one-entry skid
// buffer (HOLD) and forwarded once the stall drops. A redirect while a
// request is outstanding marks that response for discard.
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned   PC_WIDTH  = 32,
   parameter logic [31:0]   RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0]   NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                arst_n,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_rdata,
   input  logic                imem_valid,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jump_target,
   output logic                if_id_valid,
   output logic [31:0]         if_id_instr,
   output logic [PC_WIDTH-1:0] if_id_pc_plus4,
   output logic [5:0]          if_id_opcode
);

   fetch_state_e        state_d, state_q;
   logic [PC_WIDTH-1:0] pc_d, pc_q;
   logic [31:0]         buf_d, buf_q;
   logic                discard_d, discard_q;
   logic                req_d, req_q;

   logic                redirect;
   logic [PC_WIDTH-1:0] redirect_raw;
   logic [PC_WIDTH-1:0] redirect_pc;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic                ifid_load;
   logic                ifid_flush;
   logic [31:0]         ifid_instr;

   assign redirect     = branch_taken | jump;
   assign redirect_raw = branch_taken ? branch_target : jump_target;
   assign redirect_pc  = redirect_raw & ~PC_WIDTH'(3);
   assign pc_plus4     = pc_q + PC_WIDTH'(4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      buf_d      = buf_q;
      discard_d  = discard_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      ifid_instr = imem_rdata;

      if (redirect) begin
         pc_d       = redirect_pc;
         ifid_flush = 1'b1;
         buf_d      = '0;
      end

      unique case (state_q)
         FETCH_BOOT: begin
            state_d = FETCH_ISSUE;
         end
         FETCH_ISSUE: begin
            // The request goes out this cycle, so a redirect now must drop its response.
            state_d = FETCH_WAIT;
            if (redirect) discard_d = 1'b1;
         end
         FETCH_WAIT: begin
            if (redirect) begin
               if (imem_valid) begin
                  discard_d = 1'b0;
                  state_d   = FETCH_ISSUE;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (imem_valid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = FETCH_ISSUE;
               end else if (!stall) begin
                  ifid_load = 1'b1;
                  pc_d      = pc_plus4;
                  state_d   = FETCH_ISSUE;
               end else begin
                  buf_d   = imem_rdata;
                  state_d = FETCH_HOLD;
               end
            end
         end
         FETCH_HOLD: begin
            if (redirect) begin
               state_d = FETCH_ISSUE;
            end else if (!stall) begin
               ifid_load  = 1'b1;
               ifid_instr = buf_q;
               pc_d       = pc_plus4;
               state_d    = FETCH_ISSUE;
            end
         end
         default: state_d = FETCH_BOOT;
      endcase

      req_d = (state_d == FETCH_ISSUE);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= FETCH_BOOT;
         pc_q      <= RESET_PC[PC_WIDTH-1:0];
         buf_q     <= '0;
         discard_q <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         buf_q     <= buf_d;
         discard_q <= discard_d;
         req_q     <= req_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;

   if_id_pipe_reg #(
      .PC_WIDTH  (PC_WIDTH),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .arst_n     (arst_n),
      .load_i     (ifid_load),
      .flush_i    (ifid_flush),
      .instr_i    (ifid_instr),
      .pc_plus4_i (pc_plus4),
      .valid_o    (if_id_valid),
      .instr_o    (if_id_instr),
      .pc_plus4_o (if_id_pc_plus4),
      .opcode_o   (if_id_opcode)
   );

   // A response is only legal while one is outstanding. BOOT is exempt: a
   // request in flight when reset hit may still land there and is ignored.
   a_valid_only_when_outstanding: assert property (
      @(posedge clk) disable iff (!arst_n)
      imem_valid |-> (state_q == FETCH_WAIT || state_q == FETCH_BOOT)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_exp_t;

   logic        clk;
   logic        arst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic [5:0]  if_id_opcode;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   logic [31:0] req_q[$];
   ifid_exp_t   ifid_q[$];

   // memory model controls
   int unsigned mem_lat  = 1;
   bit          mem_auto = 1'b1;
   logic        mem_valid_r;
   logic [31:0] mem_rdata_r;
   logic        stale_valid;
   logic [31:0] mem_a;
   int unsigned mem_lat_cur;

   assign imem_valid = mem_valid_r | stale_valid;
   assign imem_rdata = stale_valid ? 32'hDEAD_BEEF : mem_rdata_r;

   instruction_fetch_unit #(
      .PC_WIDTH  (32),
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_valid     (imem_valid),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_target    (jump_target),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_opcode   (if_id_opcode)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h2008_0005;
      return 32'h8C00_0000 | (a >> 2);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_req(input logic [31:0] addr);
      int unsigned n;
      bit hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < 60) begin
         step();
         if (imem_req === 1'b1 && imem_addr === addr) hit = 1'b1;
         n++;
      end
      if (!hit) begin
         n_vec++;
         n_miss++;
         $display("FAIL wait_req: no request for %h within 60 cycles, last addr %h", addr, imem_addr);
      end
   endtask

   // Memory: a request seen after edge P0 is answered with imem_valid
   // sampled by the DUT at edge P(mem_lat+1).
   initial begin
      mem_valid_r = 1'b0;
      mem_rdata_r = '0;
      @(posedge clk);
      #1;
      forever begin
         if (imem_req === 1'b1 && arst_n === 1'b1 && mem_auto) begin
            mem_a       = imem_addr;
            mem_lat_cur = mem_lat;
            repeat (mem_lat_cur) @(posedge clk);
            #1;
            mem_valid_r = 1'b1;
            mem_rdata_r = mem_word(mem_a);
            @(posedge clk);
            #1;
            mem_valid_r = 1'b0;
            mem_rdata_r = '0;
         end else begin
            @(posedge clk);
            #1;
         end
      end
   end

   // Request monitor
   initial begin
      forever begin
         @(negedge clk);
         if (arst_n === 1'b1 && imem_req === 1'b1) begin
            if (req_q.size() == 0) begin
               check("unexpected_req", imem_addr, 32'hFFFF_FFFF);
            end else begin
               check("req_addr", imem_addr, req_q.pop_front());
            end
         end
      end
   end

   // IF/ID monitor: a new valid entry is a load
   initial begin
      logic        prev_v;
      logic [31:0] prev_i;
      logic [31:0] prev_p;
      ifid_exp_t   e;
      prev_v = 1'b0;
      prev_i = '0;
      prev_p = '0;
      forever begin
         @(negedge clk);
         if (if_id_valid === 1'b1 &&
             (prev_v !== 1'b1 || if_id_instr !== prev_i || if_id_pc_plus4 !== prev_p)) begin
            if (ifid_q.size() == 0) begin
               check("unexpected_ifid", if_id_pc_plus4, 32'hFFFF_FFFF);
            end else begin
               e = ifid_q.pop_front();
               check("ifid_instr", if_id_instr, e.instr);
               check("ifid_pc4", if_id_pc_plus4, e.pc4);
            end
         end
         prev_v = if_id_valid;
         prev_i = if_id_instr;
         prev_p = if_id_pc_plus4;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      arst_n        = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      jump          = 1'b0;
      jump_target   = '0;
      stale_valid   = 1'b0;
      #2 arst_n = 1'b0;
      #10;
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'b0, if_id_valid}, 32'h0);
      check("rst_instr", if_id_instr, 32'h0);
      check("rst_pc4", if_id_pc_plus4, 32'h0);
      check("rst_opcode", {26'b0, if_id_opcode}, 32'h0);

      // 1: boot, 1-cycle memory
      req_q.push_back(32'h0);
      ifid_q.push_back('{32'h2008_0005, 32'h4});
      req_q.push_back(32'h4);
      ifid_q.push_back('{32'h8C00_0001, 32'h8});
      req_q.push_back(32'h8);
      @(negedge clk);
      arst_n = 1'b1;
      wait_req(32'h4);
      check("t1_opcode", {26'b0, if_id_opcode}, 32'h08);
      check("t1_pc4", if_id_pc_plus4, 32'h4);

      // 2: stall while response for addr 8 arrives
      wait_req(32'h8);
      ifid_q.push_back('{32'h8C00_0002, 32'hC});
      req_q.push_back(32'hC);
      stall = 1'b1;
      repeat (4) step();
      check("t2_hold_pc4", if_id_pc_plus4, 32'h8);
      check("t2_hold_instr", if_id_instr, 32'h8C00_0001);
      check("t2_hold_req", {31'b0, imem_req}, 32'h0);
      stall   = 1'b0;
      mem_lat = 3;

      // 3: branch during WAIT with 3-cycle memory
      wait_req(32'hC);
      req_q.push_back(32'h40);
      step();
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      step();
      branch_taken = 1'b0;
      mem_lat      = 1;
      check("t3_flush_valid", {31'b0, if_id_valid}, 32'h0);
      check("t3_flush_instr", if_id_instr, 32'h0);

      // 4: branch beats jump; target low bits forced to 00
      wait_req(32'h40);
      req_q.push_back(32'h80);
      branch_taken  = 1'b1;
      branch_target = 32'h80;
      jump          = 1'b1;
      jump_target   = 32'h100;
      step();
      branch_taken = 1'b0;
      jump         = 1'b0;
      wait_req(32'h80);
      req_q.push_back(32'h100);
      ifid_q.push_back('{32'h8C00_0040, 32'h104});
      req_q.push_back(32'h104);
      jump        = 1'b1;
      jump_target = 32'h103;
      step();
      jump = 1'b0;
      wait_req(32'h100);
      wait_req(32'h104);
      check("t4_pc4", if_id_pc_plus4, 32'h104);

      // 5: PC wrap
      req_q.push_back(32'hFFFF_FFFC);
      ifid_q.push_back('{32'hBFFF_FFFF, 32'h0});
      req_q.push_back(32'h0);
      jump        = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      step();
      jump = 1'b0;
      wait_req(32'hFFFF_FFFC);
      mem_auto = 1'b0;
      wait_req(32'h0);
      check("t5_wrap_pc4", if_id_pc_plus4, 32'h0);
      check("t5_wrap_valid", {31'b0, if_id_valid}, 32'h1);

      // 6: reset during WAIT, stale response in BOOT
      step();
      arst_n = 1'b0;
      #1;
      check("t6_rst_req", {31'b0, imem_req}, 32'h0);
      check("t6_rst_addr", imem_addr, 32'h0);
      check("t6_rst_valid", {31'b0, if_id_valid}, 32'h0);
      check("t6_rst_instr", if_id_instr, 32'h0);
      check("t6_rst_pc4", if_id_pc_plus4, 32'h0);
      req_q.push_back(32'h0);
      ifid_q.push_back('{32'h2008_0005, 32'h4});
      req_q.push_back(32'h4);
      repeat (2) @(posedge clk);
      mem_lat  = 1;
      mem_auto = 1'b1;
      @(negedge clk);
      arst_n      = 1'b1;
      stale_valid = 1'b1;
      @(posedge clk);
      #1;
      stale_valid = 1'b0;
      #1;
      check("t6_issue_req", {31'b0, imem_req}, 32'h1);
      check("t6_issue_valid", {31'b0, if_id_valid}, 32'h0);
      step();
      check("t6_wait_valid", {31'b0, if_id_valid}, 32'h0);
      wait_req(32'h4);
      check("t6_opcode", {26'b0, if_id_opcode}, 32'h08);
      check("t6_pc4", if_id_pc_plus4, 32'h4);

      @(negedge clk);
      #1;
      check("req_queue_empty", req_q.size(), 32'h0);
      check("ifid_queue_empty", ifid_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
